// File: rtl/swg_frame_sequencer.sv
// Frame sequencer around a sliding-window generator: admits one input frame at a time, tags the last window with TLAST, flushes the SWG on abort.
// Stream gating is combinational (zero latency); backpressure passes straight through, input is held off outside FILL and output outside FILL/DRAIN.
module swg_frame_sequencer #(
  parameter int BIT_WIDTH    = 8,
  parameter int SIMD         = 1,
  parameter int K            = 3,
  parameter int IFM_W        = 256,
  parameter int IFM_H        = 256,
  parameter int OFM_W        = 254,
  parameter int OFM_H        = 254,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic                          cfg_start,
  input  logic [15:0]                   cfg_num_frames,
  input  logic                          cfg_abort,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   frames_done,
  output logic                          err,
  input  logic                          in0_V_V_TVALID,
  output logic                          in0_V_V_TREADY,
  input  logic [BIT_WIDTH*SIMD-1:0]     in0_V_V_TDATA,
  output logic                          swg_in_TVALID,
  input  logic                          swg_in_TREADY,
  output logic [BIT_WIDTH*SIMD-1:0]     swg_in_TDATA,
  input  logic                          swg_out_TVALID,
  output logic                          swg_out_TREADY,
  input  logic [BIT_WIDTH*SIMD*K*K-1:0] swg_out_TDATA,
  output logic                          out_V_V_TVALID,
  input  logic                          out_V_V_TREADY,
  output logic [BIT_WIDTH*SIMD*K*K-1:0] out_V_V_TDATA,
  output logic                          out_V_V_TLAST,
  output logic                          swg_rst_n
);

  localparam int IN_ELEMS = IFM_W * IFM_H;
  localparam int WINS     = OFM_W * OFM_H;
  localparam int IN_W     = $clog2(IN_ELEMS + 1);
  localparam int WIN_W    = $clog2(WINS + 1);
  localparam int FL_W     = $clog2(FLUSH_CYCLES + 1);

  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_ELEMS - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINS - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_FLUSH} state_t;

  state_t            state, state_nxt;
  logic [IN_W-1:0]   in_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [FL_W-1:0]   flush_cnt;
  logic [15:0]       frames_tot;
  logic              gate_in, gate_out, swg_flush;
  logic              in_xfer, out_xfer, in_last, frame_end, last_frame;
  logic              start_acc, zero_start, abort_acc, flush_last, active;

  assign in0_V_V_TREADY = swg_in_TREADY & gate_in;
  assign swg_in_TVALID  = in0_V_V_TVALID & gate_in;
  assign swg_in_TDATA   = in0_V_V_TDATA;
  assign out_V_V_TVALID = swg_out_TVALID & gate_out;
  assign swg_out_TREADY = out_V_V_TREADY & gate_out;
  assign out_V_V_TDATA  = swg_out_TDATA;
  assign out_V_V_TLAST  = (win_cnt == WIN_LAST) & out_V_V_TVALID;
  assign swg_rst_n      = ~ap_rst & ~swg_flush;

  assign in_xfer    = in0_V_V_TVALID & in0_V_V_TREADY;
  assign out_xfer   = out_V_V_TVALID & out_V_V_TREADY;
  assign in_last    = in_xfer & (in_cnt == IN_LAST);
  assign frame_end  = out_xfer & (win_cnt == WIN_LAST);
  assign last_frame = (frames_done == frames_tot - 16'd1);
  assign active     = (state == S_FILL) | (state == S_DRAIN);
  assign start_acc  = (state == S_IDLE) & cfg_start & (cfg_num_frames != 16'd0);
  assign zero_start = (state == S_IDLE) & cfg_start & (cfg_num_frames == 16'd0);
  assign abort_acc  = cfg_abort & active;
  assign flush_last = (flush_cnt == FL_LAST);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_acc) state_nxt = S_FILL;
      S_FILL: begin
        if (abort_acc)      state_nxt = S_FLUSH;
        else if (frame_end) state_nxt = last_frame ? S_IDLE : S_FILL;
        else if (in_last)   state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_acc)      state_nxt = S_FLUSH;
        else if (frame_end) state_nxt = last_frame ? S_IDLE : S_FILL;
      end
      S_FLUSH: if (flush_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gate_in   = 1'b0;
    gate_out  = 1'b0;
    busy      = 1'b0;
    swg_flush = 1'b0;
    case (state)
      S_FILL:  begin gate_in = 1'b1; gate_out = 1'b1; busy = 1'b1; end
      S_DRAIN: begin gate_out = 1'b1; busy = 1'b1; end
      S_FLUSH: begin swg_flush = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  // Abort outranks frame end: an aborted frame is never counted and never raises done.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      in_cnt      <= '0;
      win_cnt     <= '0;
      frames_done <= '0;
      frames_tot  <= '0;
      done        <= 1'b0;
    end else begin
      done <= zero_start | (frame_end & last_frame & ~abort_acc);
      if (start_acc) begin
        in_cnt      <= '0;
        win_cnt     <= '0;
        frames_done <= '0;
        frames_tot  <= cfg_num_frames;
      end else if (abort_acc) begin
        in_cnt  <= '0;
        win_cnt <= '0;
      end else if (frame_end) begin
        // A final input beat landing in this same cycle is dropped with the counter clear.
        in_cnt      <= '0;
        win_cnt     <= '0;
        frames_done <= frames_done + 16'd1;
      end else begin
        if (in_xfer)  in_cnt  <= in_cnt + 1'b1;
        if (out_xfer) win_cnt <= win_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      flush_cnt <= '0;
      err       <= 1'b0;
    end else begin
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;
      // A stray SWG beat in the same cycle as an accepted start still flags.
      if (start_acc) err <= 1'b0;
      if (swg_out_TVALID & ~active) err <= 1'b1;
    end
  end

endmodule
